// File: rtl/wbm_stream_initiator.sv
// Wishbone classic initiator: one (direction, offset, length) command becomes single-word beats
// with valid/ready write and read streams. Define WBM_CHECKSUM_EN to enable the data checksum.
module wbm_stream_initiator #(
  parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
  parameter int          LEN_W     = 16,
  parameter int          TIMEOUT   = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] beats_done,
  output logic [31:0]      checksum
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             write_reg;
  logic [LEN_W-1:0] len_reg;
  logic [TW-1:0]    tmo_cnt_reg;
  logic             accept;
  logic             ack_hit;
  logic             tmo_hit;
  logic             we_next;
  logic             unused_addr_bits;

  assign cmd_ready = (state_reg == S_IDLE);
  assign wr_ready  = (state_reg == S_FETCH);
  assign busy      = (state_reg != S_IDLE);

  assign accept  = cmd_valid && cmd_ready;
  assign ack_hit = (state_reg == S_REQ) && wbm_ack_i;
  // An ack in the final allowed cycle wins over the timeout.
  assign tmo_hit = (state_reg == S_REQ) && !wbm_ack_i && (tmo_cnt_reg == TW'(TIMEOUT - 1));

  assign unused_addr_bits = ^{cmd_addr[31:20], cmd_addr[1:0]};

  always_comb begin
    state_next = state_reg;
    we_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (cmd_len == '0)  state_next = S_FIN;
          else if (cmd_write) state_next = S_FETCH;
          else                state_next = S_REQ;
        end
      end
      S_FETCH: begin
        if (wr_valid) state_next = S_REQ;
      end
      S_REQ: begin
        if (wbm_ack_i) begin
          if (!write_reg)                                state_next = S_DRAIN;
          else if ((beats_done + LEN_W'(1)) == len_reg)  state_next = S_FIN;
          else                                           state_next = S_FETCH;
        end else if (tmo_hit) begin
          state_next = S_FIN;
        end
      end
      S_DRAIN: begin
        if (rd_ready) state_next = (beats_done == len_reg) ? S_FIN : S_REQ;
      end
      S_FIN: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Bus strobes are registered from the next state so they line up with REQ exactly.
    if (state_next == S_REQ) we_next = (state_reg == S_IDLE) ? cmd_write : write_reg;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_reg   <= S_IDLE;
      write_reg   <= 1'b0;
      len_reg     <= '0;
      tmo_cnt_reg <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= 4'h0;
      wbm_adr_o   <= 32'h0;
      wbm_dat_o   <= 32'h0;
      rd_data     <= 32'h0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      beats_done  <= '0;
    end else begin
      state_reg   <= state_next;
      wbm_cyc_o   <= (state_next == S_REQ);
      wbm_stb_o   <= (state_next == S_REQ);
      wbm_sel_o   <= {4{state_next == S_REQ}};
      wbm_we_o    <= we_next;
      rd_valid    <= (state_next == S_DRAIN);
      done        <= (state_reg == S_FIN);
      tmo_cnt_reg <= (state_reg == S_REQ) ? tmo_cnt_reg + 1'b1 : '0;

      if (accept) begin
        write_reg  <= cmd_write;
        len_reg    <= cmd_len;
        wbm_adr_o  <= {ADDR_BASE[31:20], cmd_addr[19:2], 2'b00};
        err        <= 1'b0;
        beats_done <= '0;
      end

      if ((state_reg == S_FETCH) && wr_valid) wbm_dat_o <= wr_data;

      if (ack_hit) begin
        beats_done       <= beats_done + 1'b1;
        // Offset wraps inside the 1 MiB window; the base bits never change.
        wbm_adr_o[19:2]  <= wbm_adr_o[19:2] + 1'b1;
        if (!write_reg) rd_data <= wbm_dat_i;
      end

      if (tmo_hit) err <= 1'b1;
    end
  end

`ifdef WBM_CHECKSUM_EN
  logic [31:0] sum_reg;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      sum_reg <= 32'h0;
    end else if (accept) begin
      sum_reg <= 32'h0;
    end else if (ack_hit) begin
      sum_reg <= sum_reg + (write_reg ? wbm_dat_o : wbm_dat_i);
    end
  end

  assign checksum = sum_reg;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_wbm_stream_initiator.sv
// Bench for wbm_stream_initiator: table of directed commands, hand-written corner sequences and
// random commands, all checked against a transaction-level model of the expected bus traffic.
module tb_wbm_stream_initiator;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [15:0] cmd_len = 16'h0;
  logic [31:0] wr_data = 32'h0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;
  logic        busy, done, err;
  logic [15:0] beats_done;
  logic [31:0] checksum;

  always #5 clk = ~clk;

  wbm_stream_initiator #(.ADDR_BASE(32'h3800_0000), .LEN_W(16), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .busy(busy), .done(done), .err(err), .beats_done(beats_done), .checksum(checksum)
  );

  int n_vec = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Environment knobs set by the test, read by the environment process.
  int          ack_delay = 0;
  int          rd_stall = 0;
  int          wr_gap = 0;
  bit          spurious_en = 1'b0;
  logic [31:0] data_base = 32'h0;

  logic [31:0] bus_adr_q[$];
  logic [31:0] bus_wdat_q[$];
  logic        bus_we_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wr_src_q[$];

  int          resp_cnt = 0, rd_wait = 0, wr_gap_cnt = 0;
  int          stb_run = 0, last_stb_run = 0, done_cnt = 0;
  bit          wr_xfer = 1'b0, prev_stb = 1'b0, prev_rdv = 1'b0, prev_rdr = 1'b0, any_cyc = 1'b0;
  logic [31:0] prev_adr = 32'h0, prev_dat = 32'h0, prev_rdata = 32'h0;

  // Responder, stream source/sink and protocol monitor, all acting on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      wbm_ack_i = 1'b0; resp_cnt = 0; rd_ready = 1'b0; rd_wait = 0;
      wr_valid = 1'b0; wr_xfer = 1'b0; wr_gap_cnt = 0;
      prev_stb = 1'b0; prev_rdv = 1'b0; prev_rdr = 1'b0; stb_run = 0;
    end else begin
      if (wbm_cyc_o) any_cyc = 1'b1;
      if (done) done_cnt++;

      if (wbm_ack_i) begin
        wbm_ack_i = 1'b0;
        resp_cnt  = 0;
      end else if (wbm_cyc_o && wbm_stb_o) begin
        if (resp_cnt == ack_delay) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = data_base + {14'd0, wbm_adr_o[19:2]};
          bus_adr_q.push_back(wbm_adr_o);
          bus_we_q.push_back(wbm_we_o);
          if (wbm_we_o) bus_wdat_q.push_back(wbm_dat_o);
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt  = 0;
        wbm_dat_i = $urandom;
        if (spurious_en && ($urandom_range(0, 3) == 0)) wbm_ack_i = 1'b1;
      end

      if (wbm_stb_o) begin
        check("sel_during_stb", 32'(wbm_sel_o), 32'hF);
        check("cyc_with_stb", 32'(wbm_cyc_o), 32'h1);
        check("no_req_while_draining", 32'(rd_valid), 32'h0);
        if (prev_stb) begin
          check("adr_hold", wbm_adr_o, prev_adr);
          check("dat_hold", wbm_dat_o, prev_dat);
        end
        stb_run++;
      end else begin
        if (stb_run != 0) last_stb_run = stb_run;
        stb_run = 0;
      end
      if (wr_ready) check("no_stb_in_fetch", 32'(wbm_stb_o), 32'h0);
      prev_stb = wbm_stb_o; prev_adr = wbm_adr_o; prev_dat = wbm_dat_o;

      if (prev_rdv && !prev_rdr) begin
        check("rd_valid_hold", 32'(rd_valid), 32'h1);
        check("rd_data_hold", rd_data, prev_rdata);
      end
      if (rd_valid) begin
        rd_ready = (rd_wait >= rd_stall);
        if (!rd_ready) rd_wait++;
      end else begin
        rd_ready = 1'($urandom_range(0, 1));
        rd_wait  = 0;
      end
      if (rd_valid && rd_ready) rd_q.push_back(rd_data);
      prev_rdv = rd_valid; prev_rdr = rd_ready; prev_rdata = rd_data;

      if (wr_xfer) begin
        void'(wr_src_q.pop_front());
        wr_gap_cnt = 0;
      end
      if (wr_src_q.size() > 0 && wr_gap_cnt >= wr_gap) begin
        wr_valid = 1'b1;
        wr_data  = wr_src_q[0];
      end else begin
        wr_valid = 1'b0;
        wr_data  = $urandom;
        if (wr_src_q.size() > 0) wr_gap_cnt++;
      end
      wr_xfer = wr_valid && wr_ready;
    end
  end

  function automatic logic [17:0] word_of(input logic [31:0] a, input int i);
    return a[19:2] + 18'(i);
  endfunction

  task automatic run_cmd(input string tag, input bit wr, input logic [31:0] addr, input int len,
                         input int delay, input int rstall, input int wgap, input logic [31:0] base,
                         input int exp_beats, input bit exp_err);
    logic [31:0] wdata[$];
    logic [31:0] exp_sum;
    logic [31:0] exp_val;
    int          d0;
    int          waited;
    ack_delay = delay; rd_stall = rstall; wr_gap = wgap; data_base = base;
    bus_adr_q.delete(); bus_wdat_q.delete(); bus_we_q.delete(); rd_q.delete();
    wdata.delete();
    if (wr) for (int i = 0; i < len; i++) wdata.push_back($urandom);
    wr_src_q = wdata;
    d0 = done_cnt;
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = 16'(len);
    @(negedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 16'($urandom);
    check({tag, " busy"}, 32'(busy), 32'h1);
    waited = 0;
    while (done_cnt == d0 && waited < 3000) begin
      @(negedge clk); #1;
      waited++;
    end
    check({tag, " done_seen"}, 32'(done_cnt - d0), 32'h1);
    check({tag, " beats_done"}, 32'(beats_done), 32'(exp_beats));
    check({tag, " err"}, 32'(err), 32'(exp_err));
    if (len > 0 && !spurious_en) check({tag, " stb_cycles"}, 32'(last_stb_run), exp_err ? 32'(TIMEOUT) : 32'(delay + 1));

    check({tag, " bus_beats"}, 32'(bus_adr_q.size()), 32'(exp_beats));
    exp_sum = 32'h0;
    for (int i = 0; i < exp_beats; i++) begin
      exp_val = wr ? wdata[i] : base + {14'd0, word_of(addr, i)};
      exp_sum += exp_val;
      if (i < bus_adr_q.size()) begin
        check($sformatf("%s adr[%0d]", tag, i), bus_adr_q[i], 32'h3800_0000 | {12'd0, word_of(addr, i), 2'b00});
        check($sformatf("%s we[%0d]", tag, i), 32'(bus_we_q[i]), 32'(wr));
      end
      if (wr && i < bus_wdat_q.size()) check($sformatf("%s wdat[%0d]", tag, i), bus_wdat_q[i], exp_val);
      if (!wr && i < rd_q.size()) check($sformatf("%s rdat[%0d]", tag, i), rd_q[i], exp_val);
    end
    if (!wr) check({tag, " rd_count"}, 32'(rd_q.size()), 32'(exp_beats));
`ifdef WBM_CHECKSUM_EN
    check({tag, " checksum"}, checksum, exp_sum);
`else
    check({tag, " checksum"}, checksum, 32'h0);
`endif
    @(negedge clk); #1;
    check({tag, " done_single"}, 32'(done_cnt - d0), 32'h1);
    wr_src_q.delete();
    $display("cmd %s: wr=%0d addr=%08h len=%0d delay=%0d beats=%0d err=%0d", tag, wr, addr, len, delay, beats_done, err);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    int          delay;
    int          rstall;
    int          wgap;
    logic [31:0] base;
    int          exp_beats;
    bit          exp_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0;
    bit          wr;
    logic [31:0] addr;
    int          len, delay;

    tbl[0] = '{1'b0, 32'h0000_0010, 4, 11,   0,  0, 32'h0000_009C, 4, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0100, 3, 0,    0,  5, 32'h0,         3, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0000, 1, 63,   0,  0, 32'h1234_0000, 1, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0040, 3, 1000, 0,  0, 32'h0,         0, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0008, 2, 64,   0,  0, 32'h0,         0, 1'b1};
    tbl[5] = '{1'b0, 32'h0000_0020, 2, 0,    20, 0, 32'h5555_0000, 2, 1'b0};
    tbl[6] = '{1'b0, 32'hABCF_FFFB, 4, 1,    1,  0, 32'h7000_0000, 4, 1'b0};
    tbl[7] = '{1'b1, 32'h000F_FFFC, 3, 2,    0,  1, 32'h0,         3, 1'b0};
    tbl[8] = '{1'b0, 32'h0000_0030, 0, 0,    0,  0, 32'h0,         0, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    check("reset cmd_ready", 32'(cmd_ready), 32'h1);
    check("reset busy", 32'(busy), 32'h0);
    check("reset cyc", 32'(wbm_cyc_o), 32'h0);
    check("reset stb", 32'(wbm_stb_o), 32'h0);
    check("reset adr", wbm_adr_o, 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset err", 32'(err), 32'h0);
    check("reset beats", 32'(beats_done), 32'h0);
    check("reset rd_valid", 32'(rd_valid), 32'h0);
    check("reset wr_ready", 32'(wr_ready), 32'h0);
    check("reset checksum", checksum, 32'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_cmd($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].delay,
              tbl[i].rstall, tbl[i].wgap, tbl[i].base, tbl[i].exp_beats, tbl[i].exp_err);
    end

    // Timeout, then a zero-length command that must clear err and finish without bus activity.
    run_cmd("tmo", 1'b0, 32'h0000_0200, 2, 1000, 0, 0, 32'h0, 0, 1'b1);
    check("tmo err before next", 32'(err), 32'h1);
    any_cyc = 1'b0;
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_len = 16'h0;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    check("len0 err cleared", 32'(err), 32'h0);
    check("len0 busy", 32'(busy), 32'h1);
    check("len0 done not yet", 32'(done), 32'h0);
    @(negedge clk); #1;
    check("len0 done at +2", 32'(done), 32'h1);
    check("len0 cmd_ready", 32'(cmd_ready), 32'h1);
    check("len0 beats", 32'(beats_done), 32'h0);
    @(negedge clk); #1;
    check("len0 done count", 32'(done_cnt - d0), 32'h1);
    check("len0 no cyc", 32'(any_cyc), 32'h0);

    spurious_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = $urandom;
      len   = $urandom_range(0, 5);
      delay = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 3);
      run_cmd($sformatf("rnd%0d", i), wr, addr, len, delay, $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom, (delay < TIMEOUT) ? len : 0,
              (len > 0) && (delay >= TIMEOUT));
    end
    spurious_en = 1'b0;

    // Asynchronous reset in the middle of a request.
    ack_delay = 1000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80; cmd_len = 16'd3;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("pre-reset cyc", 32'(wbm_cyc_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async cyc", 32'(wbm_cyc_o), 32'h0);
    check("async stb", 32'(wbm_stb_o), 32'h0);
    check("async busy", 32'(busy), 32'h0);
    check("async cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post-reset cmd_ready", 32'(cmd_ready), 32'h1);
    check("post-reset cyc", 32'(wbm_cyc_o), 32'h0);
    $display("reset mid-request: cyc=%0d busy=%0d cmd_ready=%0d", wbm_cyc_o, busy, cmd_ready);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wbm_stream_initiator.md
Name: wbm_stream_initiator

Overview:
Wishbone classic initiator. It turns a single command (direction, start address, word count) into a sequence of single-word Wishbone transactions toward the user-area responder window at 0x3800_0000. Write data comes in on a valid/ready stream and read data goes out on a valid/ready stream. A per-beat timeout guards against responders that never acknowledge.

Parameters:
- ADDR_BASE, 32'h3800_0000, OR'd into every issued address; only bits [31:20] are used, so a command offset must stay below 1 MiB.
- LEN_W, 16, width of cmd_len and beats_done.
- TIMEOUT, 64, maximum number of REQ cycles without ack before a beat is aborted; must be at least 2.

Ports:
- wb_clk_i  in  1  clock
- wb_rstn_i  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  32  byte offset; bits [1:0] are ignored
- cmd_len  in  LEN_W  number of words; 0 means no-op
- wr_data  in  32  write stream data
- wr_valid  in  1  write stream valid
- wr_ready  out  1  write stream ready
- rd_data  out  32  read stream data
- rd_valid  out  1  read stream valid
- rd_ready  in  1  read stream ready
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone byte select
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at end of command
- err  out  1  sticky timeout flag
- beats_done  out  LEN_W  number of acknowledged beats in current command
- checksum  out  32  running read-data sum (see Optional Feature)

Behaviour:
- Reset (wb_rstn_i=0, asynchronous):
  - state=IDLE.
  - All outputs 0 except cmd_ready=1.
  - Any in-flight beat is abandoned; cyc/stb drop immediately.
- All outputs are registered except cmd_ready, wr_ready and busy, which are decoded from state.
- States: IDLE, FETCH, REQ, DRAIN, FIN.
- IDLE:
  - On cmd_valid&&cmd_ready, latch cmd_write, cmd_len and addr = ADDR_BASE | {cmd_addr[19:2],2'b00}.
  - Same edge: clear err, beats_done and checksum.
  - Next state: len==0 -> FIN (no bus activity); write -> FETCH; read -> REQ.
- FETCH:
  - wr_ready=1.
  - On wr_valid, capture wr_data into wbm_dat_o and go to REQ.
- REQ:
  - wbm_cyc_o=wbm_stb_o=1, wbm_sel_o=4'hF, wbm_we_o=cmd_write.
  - Address and data are held stable until ack.
  - On wbm_ack_i:
    - cyc/stb go low next cycle (at least one idle bus cycle between beats, which the responder's single-cycle ack requires).
    - beats_done increments; addr += 4, with wrap inside the 1 MiB window (bits [19:2] only).
    - Read: capture wbm_dat_i into rd_data and go to DRAIN.
    - Write: if beats_done+1==len go to FIN, else go to FETCH.
- DRAIN:
  - rd_valid=1; rd_data is held.
  - On rd_ready: go to FIN if last beat, else REQ.
  - rd_valid=1 with rd_ready=1 in the same cycle counts as one transfer.
- FIN: done=1 for one cycle, then IDLE.
- Timeout:
  - The beat counter is cleared on entry to REQ and counts every REQ cycle.
  - If it reaches TIMEOUT without ack: drop cyc/stb, set err=1, go to FIN; remaining beats are skipped.
  - beats_done reports the count of acknowledged beats.
- An ack arriving in the same cycle the timeout fires counts as a successful beat; timeout has lower priority.
- wbm_ack_i outside REQ is ignored.
- cmd_valid while busy is ignored; cmd_ready=0.
- Minimum beat latency with a zero-wait responder:
  - write: 3 cycles (FETCH, REQ, ack).
  - read: 3 cycles (REQ, ack, DRAIN).

Optional Feature:
- Macro: WBM_CHECKSUM_EN.
- Defined:
  - checksum += wbm_dat_i (mod 2^32) on every read ack.
  - On write acks, checksum accumulates wbm_dat_o instead.
  - Cleared on command accept; valid from the done pulse until the next accept.
- Undefined: checksum is tied to 32'h0 and the adder is not synthesized.

Test Plan:
1. Read cmd addr 0x10, len 4; responder acks after 12 cycles with data 0xA0..0xA3:
   - wbm_adr_o = 0x3800_0010/14/18/1C;
   - rd stream delivers A0..A3 in order;
   - beats_done=4, done pulses once, err=0;
   - checksum=0x286 if enabled.
2. Write cmd len 3, wr_valid held low for 5 cycles before each word:
   - no stb while in FETCH;
   - wbm_dat_o equals each captured word while stb=1;
   - we=1, sel=F.
3. len=0 command: done pulses 2 cycles after accept; cyc never asserts.
4. Responder never acks, TIMEOUT=64:
   - stb drops after exactly 64 REQ cycles;
   - err=1, beats_done=0, done pulses;
   - next command accept clears err.
5. Read len 2 with rd_ready held low for 20 cycles:
   - rd_valid and rd_data stay stable;
   - no second bus request until the drain completes.
6. Async reset asserted mid-REQ (cyc=1): cyc, stb, busy fall without a clock edge; cmd_ready=1 after release.
